// File: rtl/somador_serial_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding, default
// operand width and the signed-overflow helper.
package somador_serial_pkg;

  // FSM state encoding
  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] SOMANDO = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  // Default operand/result width
  localparam int N_PADRAO = 8;

  // Two's-complement overflow: carry into the MSB differs from carry out of it
  function automatic logic calc_ovf(input logic carry_msb, input logic carry_out);
    return carry_msb ^ carry_out;
  endfunction

endpackage

// File: rtl/somadorcompleto.sv
// Structural one-bit full-adder cell; the single datapath slice of the serial adder.
module somadorcompleto (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign s       = a_xor_b ^ cin;
  assign cout    = (a & b) | (a_xor_b & cin);

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell walks the operands LSB first,
// carry fed back through a register, sum bits shifted in from the MSB side.
// Optional feature macro: SOMADOR_SERIAL_OVF_EN adds a signed-overflow output ovf.
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int N  = N_PADRAO,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         pronto,
`ifdef SOMADOR_SERIAL_OVF_EN
  output logic         ocupado,
  output logic         ovf
`else
  output logic         ocupado
`endif
);

  // Counter value on the final (Nth) step
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  reg_a_q, reg_a_d;
  logic [N-1:0]  reg_b_q, reg_b_d;
  logic [N-1:0]  reg_s_q, reg_s_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_cout;

  // The one adder cell: current LSB pair plus the fed-back carry
  somadorcompleto u_fa (
    .a    (reg_a_q[0]),
    .b    (reg_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state logic: operand load, per-step shift/accumulate and result commit
  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    reg_s_d = reg_s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          reg_a_d = a;
          reg_b_d = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SOMANDO;
        end
      end
      SOMANDO: begin
        reg_s_d = {fa_s, reg_s_q[N-1:1]};
        carry_d = fa_cout;
        reg_a_d = {1'b0, reg_a_q[N-1:1]};
        reg_b_d = {1'b0, reg_b_q[N-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == ULTIMO) begin
          // Final step: publish the completed sum; carry_q is the carry into the MSB
          state_d = FIM;
          s_d     = {fa_s, reg_s_q[N-1:1]};
          cout_d  = fa_cout;
`ifdef SOMADOR_SERIAL_OVF_EN
          ovf_d   = calc_ovf(carry_q, fa_cout);
`endif
        end
      end
      FIM: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
      reg_a_q <= '0;
      reg_b_q <= '0;
      reg_s_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      reg_s_q <= reg_s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s       = s_q;
  assign cout    = cout_q;
  assign pronto  = (state_q == FIM);
  assign ocupado = (state_q != OCIOSO);
`ifdef SOMADOR_SERIAL_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Directed self-checking bench for somador_serial (N=8).
// Define SOMADOR_SERIAL_OVF_EN to also check the ovf output.
module tb_somador_serial;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         inicio;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic         pronto;
  logic         ocupado;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  somador_serial #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .s       (s),
    .cout    (cout),
    .pronto  (pronto),
`ifdef SOMADOR_SERIAL_OVF_EN
    .ocupado (ocupado),
    .ovf     (ovf)
`else
    .ocupado (ocupado)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until pronto is seen or the bound expires; returns ticks taken
  task automatic wait_pronto(input int start_n, output int n);
    n = start_n;
    while (!pronto && n < N + 6) begin
      tick();
      n++;
    end
  endtask

  // Count pronto pulses over a window of cycles
  task automatic count_pronto(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pronto) cnt++;
    end
  endtask

  // One full addition; returns the cycle stamp at which pronto was observed
  task automatic run_add(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic ci, input logic [N-1:0] exp_s, input logic exp_c,
                         input logic exp_o, output int pronto_cyc);
    int n;
    a = av; b = bv; cin = ci; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk({tag, ".ocupado"}, 32'(ocupado), 32'd1);
    wait_pronto(0, n);
    pronto_cyc = cyc;
    chk({tag, ".lat"}, 32'(n), 32'(N));
    chk({tag, ".s"}, 32'(s), 32'(exp_s));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_c));
`ifdef SOMADOR_SERIAL_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_o));
`else
    if (exp_o) begin end
`endif
    tick();
    chk({tag, ".pronto_drop"}, 32'(pronto), 32'd0);
    chk({tag, ".idle"}, 32'(ocupado), 32'd0);
    chk({tag, ".s_hold"}, 32'(s), 32'(exp_s));
    $display("add %s: a=%02h b=%02h cin=%0d -> s=%02h cout=%0d lat=%0d", tag, av, bv, ci, s, cout, n);
  endtask

  initial begin
    int n;
    int p1;
    int p2;
    int pc;

    rst = 1'b1; inicio = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.s", 32'(s), 32'h00);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.pronto", 32'(pronto), 32'd0);
    chk("rst.ocupado", 32'(ocupado), 32'd0);
`ifdef SOMADOR_SERIAL_OVF_EN
    chk("rst.ovf", 32'(ovf), 32'd0);
`endif
    tick();
    $display("reset: s=%02h cout=%0d pronto=%0d ocupado=%0d", s, cout, pronto, ocupado);

    // Basic and carry-chain vectors
    run_add("basic", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0, p1);
    run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, p1);
    run_add("55_aa", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, p1);
    run_add("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, p1);

    // Busy start ignored: second inicio mid-operation must not reload
    a = 8'h01; b = 8'h02; cin = 1'b0; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick(); tick();
    a = 8'hF0; b = 8'h0F; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    wait_pronto(4, n);
    chk("busy.lat", 32'(n), 32'(N));
    chk("busy.s", 32'(s), 32'h03);
    chk("busy.cout", 32'(cout), 32'd0);
    count_pronto(2 * N, pc);
    chk("busy.one_pulse", 32'(pc), 32'd0);
    chk("busy.s_hold", 32'(s), 32'h03);
    $display("busy: s=%02h cout=%0d extra_pronto=%0d", s, cout, pc);

    // Reset mid-operation: rst lands on the 4th step edge
    a = 8'hFF; b = 8'hFF; cin = 1'b1; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.s", 32'(s), 32'h03 & 32'h00);
    chk("midrst.cout", 32'(cout), 32'd0);
    chk("midrst.pronto", 32'(pronto), 32'd0);
    chk("midrst.ocupado", 32'(ocupado), 32'd0);
    count_pronto(2 * N, pc);
    chk("midrst.no_pronto", 32'(pc), 32'd0);
    $display("midrst: s=%02h cout=%0d ocupado=%0d pronto_seen=%0d", s, cout, ocupado, pc);
    run_add("ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, p1);

    // rst and inicio together: rst wins
    a = 8'h11; b = 8'h22; inicio = 1'b1; rst = 1'b1;
    tick();
    inicio = 1'b0; rst = 1'b0;
    chk("rst_win.ocupado", 32'(ocupado), 32'd0);
    chk("rst_win.s", 32'(s), 32'h00);
    $display("rst_win: ocupado=%0d s=%02h", ocupado, s);

    // Back-to-back: second start lands on edge k+N+2
    run_add("b2b_1", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, p1);
    run_add("b2b_2", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, p2);
    chk("b2b.spacing", 32'(p2 - p1), 32'(N + 2));
    $display("b2b: pronto spacing=%0d", p2 - p1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
